// File: rtl/input_frame_receiver.sv
// Receives a row-major pixel stream into a two-bank frame buffer and presents
// each completed frame on a random-access read port with a release handshake.
module input_frame_receiver #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              frame_ready,
  output logic              rd_bank,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  output logic              overflow,
  output logic              sof_err,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned  N      = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST_A = AW'(N - 1);
  localparam logic [AW-1:0] N_A    = AW'(N);

  typedef enum logic {S_RECV, S_WAIT} state_t;

  state_t            state_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [7:0]        frame_cnt_q;
  logic              overflow_q;
  logic              sof_err_q;
  logic              in_ready_q;
  logic              frame_ready_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] bank0_mem [0:N-1];
  logic [DATA_W-1:0] bank1_mem [0:N-1];

  logic          accept_c;
  logic          sof_restart_c;
  logic [AW-1:0] waddr_c;
  logic          last_c;
  logic          release_c;

  // A premature SOF restarts the frame at address 0 instead of appending.
  assign accept_c      = (state_q == S_RECV) && in_valid;
  assign sof_restart_c = accept_c && in_sof && (wr_ptr_q != '0);
  assign waddr_c       = sof_restart_c ? '0 : wr_ptr_q;
  assign last_c        = accept_c && (waddr_c == LAST_A);
  assign release_c     = rd_done && bank_full_q[rd_bank_q];

  always_comb begin
    bank_full_d = bank_full_q;
    rd_bank_d   = rd_bank_q ^ release_c;
    wr_bank_d   = wr_bank_q ^ last_c;
    wr_ptr_d    = wr_ptr_q;
    if (release_c) bank_full_d[rd_bank_q] = 1'b0;
    if (last_c)    bank_full_d[wr_bank_q] = 1'b1;
    if (last_c)        wr_ptr_d = '0;
    else if (accept_c) wr_ptr_d = waddr_c + AW'(1);
  end

  // Write FSM and all control registers; release and completion may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RECV;
      wr_ptr_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      frame_cnt_q   <= 8'd0;
      overflow_q    <= 1'b0;
      sof_err_q     <= 1'b0;
      in_ready_q    <= 1'b1;
      frame_ready_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      bank_full_q   <= bank_full_d;
      frame_ready_q <= bank_full_d[rd_bank_d];
      if (last_c)        frame_cnt_q <= frame_cnt_q + 8'd1;
      if (sof_restart_c) sof_err_q   <= 1'b1;
      case (state_q)
        S_RECV: begin
          if (last_c && bank_full_d[wr_bank_d]) begin
            state_q    <= S_WAIT;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (in_valid) overflow_q <= 1'b1;
          if (!bank_full_d[wr_bank_q]) begin
            state_q    <= S_RECV;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_RECV;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Frame storage is never cleared; a reset just abandons the partial frame.
  always_ff @(posedge clk) begin
    if (!rst && accept_c) begin
      if (wr_bank_q) bank1_mem[waddr_c] <= in_data;
      else           bank0_mem[waddr_c] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      if (rd_addr >= N_A)  rd_data_q <= '0;
      else if (rd_bank_q)  rd_data_q <= bank1_mem[rd_addr];
      else                 rd_data_q <= bank0_mem[rd_addr];
    end
  end

  assign in_ready    = in_ready_q;
  assign frame_ready = frame_ready_q;
  assign rd_bank     = rd_bank_q;
  assign rd_data     = rd_data_q;
  assign overflow    = overflow_q;
  assign sof_err     = sof_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
